// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//
// Turns a one-at-a-time register command (read or write) into a single
// AXI4-Lite transaction and hands the slave's answer back on a buffered
// response port. Only one transaction is ever in flight; o_cmd_ready stays low
// from the cycle after acceptance until the response has been consumed.
//
// Optional feature (compile-time macro AXI_LITE_MASTER_TIMEOUT_EN):
//   when defined, a watchdog counts cycles spent waiting for B/R. After
//   TIMEOUT_CYCLES cycles without a response the block answers by itself with
//   resp 2'b11, data 0 and o_rsp_timeout=1. A B/R that arrives later is not
//   tracked. When the macro is undefined the block waits indefinitely and
//   o_rsp_timeout is constant 0.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready  command handshake
//   i_cmd_write                1 = write, 0 = read
//   i_cmd_addr/data/strb       command byte address, write data, write strobes
//   o_rsp_valid / i_rsp_ready  response handshake (fields held until accepted)
//   o_rsp_data                 read data (0 for writes and timeouts)
//   o_rsp_resp                 BRESP/RRESP pass-through, 2'b11 on timeout
//   o_rsp_timeout              response produced by the watchdog
//   AW/W/B/AR/R channels       AXI4-Lite master side
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   // command port
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic                    i_cmd_write,
   input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [DATA_WIDTH-1:0]   i_cmd_data,
   input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
   // response port
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic [1:0]              o_rsp_resp,
   output logic                    o_rsp_timeout,
   // AXI write address
   output logic                    o_awvalid,
   input  logic                    i_awready,
   output logic [ADDR_WIDTH-1:0]   o_awaddr,
   // AXI write data
   output logic                    o_wvalid,
   input  logic                    i_wready,
   output logic [DATA_WIDTH-1:0]   o_wdata,
   output logic [STROBE_WIDTH-1:0] o_wstrb,
   // AXI write response
   input  logic                    i_bvalid,
   output logic                    o_bready,
   input  logic [1:0]              i_bresp,
   // AXI read address
   output logic                    o_arvalid,
   input  logic                    i_arready,
   output logic [ADDR_WIDTH-1:0]   o_araddr,
   // AXI read data
   input  logic                    i_rvalid,
   output logic                    o_rready,
   input  logic [1:0]              i_rresp,
   input  logic [DATA_WIDTH-1:0]   i_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WAIT_B,
      S_RD,
      S_WAIT_R,
      S_RSP
   } state_t;

   state_t                  state_q, state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    rsp_timeout_q, rsp_timeout_d;

   // High when the watchdog expires on this edge (only meaningful in WAIT_B/WAIT_R).
   logic                    to_hit;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

   // Counter is zero on entry to a wait state and counts every cycle spent
   // there; hitting TIMEOUT_CYCLES-1 on an edge means that edge is the
   // TIMEOUT_CYCLES-th one since entry.
   always_comb begin
      to_cnt_d = '0;
      if ((state_q == S_WAIT_B) || (state_q == S_WAIT_R)) begin
         to_cnt_d = to_cnt_q + CNT_W'(1);
      end
   end

   assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign to_hit             = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

   // Next-state and next-output logic. Every output register has its own
   // next value here so that the ports remain plain flop outputs.
   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      awaddr_d      = awaddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      araddr_d      = araddr_q;
      rsp_data_d    = rsp_data_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         S_IDLE: begin
            // Ready is raised one cycle into IDLE, both after reset and after
            // a completed response; this gives the 5-cycle command spacing.
            cmd_ready_d = 1'b1;
            if (i_cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               if (i_cmd_write) begin
                  awaddr_d  = i_cmd_addr;
                  wdata_d   = i_cmd_data;
                  wstrb_d   = i_cmd_strb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  araddr_d  = i_cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = S_RD;
               end
            end
         end

         S_WR: begin
            // AW and W complete independently; a channel already handshaken
            // has its valid low and counts as done.
            if (awvalid_q && i_awready) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && i_wready) begin
               wvalid_d = 1'b0;
            end
            if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) begin
               bready_d = 1'b1;
               state_d  = S_WAIT_B;
            end
         end

         S_WAIT_B: begin
            if (bready_q && i_bvalid) begin
               bready_d      = 1'b0;
               rsp_data_d    = '0;
               rsp_resp_d    = i_bresp;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RSP;
            end else if (to_hit) begin
               bready_d      = 1'b0;
               rsp_data_d    = '0;
               rsp_resp_d    = 2'b11;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = S_RSP;
            end
         end

         S_RD: begin
            if (arvalid_q && i_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_WAIT_R;
            end
         end

         S_WAIT_R: begin
            if (rready_q && i_rvalid) begin
               rready_d      = 1'b0;
               rsp_data_d    = i_rdata;
               rsp_resp_d    = i_rresp;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RSP;
            end else if (to_hit) begin
               rready_d      = 1'b0;
               rsp_data_d    = '0;
               rsp_resp_d    = 2'b11;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = S_RSP;
            end
         end

         S_RSP: begin
            if (rsp_valid_q && i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b0;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         araddr_q      <= '0;
         rsp_data_q    <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         araddr_q      <= araddr_d;
         rsp_data_q    <= rsp_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign o_cmd_ready   = cmd_ready_q;
   assign o_awvalid     = awvalid_q;
   assign o_awaddr      = awaddr_q;
   assign o_wvalid      = wvalid_q;
   assign o_wdata       = wdata_q;
   assign o_wstrb       = wstrb_q;
   assign o_bready      = bready_q;
   assign o_arvalid     = arvalid_q;
   assign o_araddr      = araddr_q;
   assign o_rready      = rready_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_resp    = rsp_resp_q;
   // Never set without the watchdog, so constant 0 in that build.
   assign o_rsp_timeout = rsp_timeout_q;

endmodule
